// File: rtl/rf_core_8x16_pkg.sv
// Shared types and constants for the WISC 8x16 register file.
// Consumers: rf_core_8x16_if, rf_read_port, rf_core_8x16.
package rf_core_8x16_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 2;
  localparam int NPORTS = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [CNT_W-1:0]  sb_cnt_t;

  // Highest in-flight write count a register can track.
  localparam sb_cnt_t SB_CNT_MAX = 2'd3;

  // Writeback request as seen by storage and the read-port bypass.
  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    reg_data_t data;
  } wr_req_t;

  // Read-port response.
  typedef struct packed {
    reg_data_t data;
    logic      busy;
  } rd_rsp_t;

  // One-hot register select, all zero when en is low.
  function automatic logic [NREGS-1:0] dec_onehot(input logic en, input reg_addr_t a);
    dec_onehot    = '0;
    dec_onehot[a] = en;
  endfunction

endpackage

// File: rtl/rf_core_8x16_if.sv
// Issue/writeback/read bus of the register file.
// master = decode/writeback side, slave = register file.
interface rf_core_8x16_if;
  import rf_core_8x16_pkg::*;

  logic                   issue_en;
  reg_addr_t              issue_reg;
  logic                   wr_en;
  reg_addr_t              wr_reg;
  reg_data_t              wr_data;
  reg_addr_t              rd1_reg;
  reg_addr_t              rd2_reg;
  reg_data_t              rd1_data;
  reg_data_t              rd2_data;
  logic                   rd1_busy;
  logic                   rd2_busy;
  logic [NREGS*DATA_W-1:0] regs_flat;
  logic                   sb_err;

  modport master (
    output issue_en, issue_reg, wr_en, wr_reg, wr_data, rd1_reg, rd2_reg,
    input  rd1_data, rd2_data, rd1_busy, rd2_busy, regs_flat, sb_err
  );

  modport slave (
    input  issue_en, issue_reg, wr_en, wr_reg, wr_data, rd1_reg, rd2_reg,
    output rd1_data, rd2_data, rd1_busy, rd2_busy, regs_flat, sb_err
  );

endinterface

// File: rtl/rf_read_port.sv
// One register-file read port: 8:1 data select plus busy lookup.
// Optional macro RF_BYPASS_EN: same-cycle writeback forwarding onto the
// port, and busy drop when that write retires the last outstanding one.
module rf_read_port
  import rf_core_8x16_pkg::*;
(
  input  logic [NREGS-1:0][DATA_W-1:0] regs,
  input  logic [NREGS-1:0][CNT_W-1:0]  cnt,
  input  wr_req_t                      wr,
  input  reg_addr_t                    addr,
  output rd_rsp_t                      rsp
);

  reg_data_t sel_data;
  sb_cnt_t   sel_cnt;

  assign sel_data = regs[addr];
  assign sel_cnt  = cnt[addr];

`ifdef RF_BYPASS_EN
  logic hit;
  assign hit      = wr.en && (wr.addr == addr);
  assign rsp.data = hit ? wr.data : sel_data;
  // A matching write that retires the final in-flight write clears busy now.
  assign rsp.busy = (sel_cnt != '0) && !(hit && (sel_cnt == sb_cnt_t'(1)));
`else
  logic unused_wr;
  assign unused_wr = ^wr;
  assign rsp.data  = sel_data;
  assign rsp.busy  = (sel_cnt != '0);
`endif

endmodule

// File: rtl/rf_core_8x16.sv
// WISC architectural register file: 8 x 16-bit, one write, two read ports,
// plus a per-register in-flight write scoreboard for RAW stall detection.
// Optional macro RF_BYPASS_EN enables write-through on the read ports
// (regs_flat always shows registered state).
module rf_core_8x16
  import rf_core_8x16_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  rf_core_8x16_if.slave bus
);

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0][CNT_W-1:0]  cnt;
  logic [NREGS-1:0][CNT_W-1:0]  cnt_nxt;
  logic                         sb_err;
  logic                         err_set;
  logic [NREGS-1:0]             iss_hit;
  logic [NREGS-1:0]             wr_hit;
  wr_req_t                      wr;

  logic [NPORTS-1:0][ADDR_W-1:0] rd_addr;
  rd_rsp_t [NPORTS-1:0]          rd_rsp;

  assign wr      = '{en: bus.wr_en, addr: bus.wr_reg, data: bus.wr_data};
  assign iss_hit = dec_onehot(bus.issue_en, bus.issue_reg);
  assign wr_hit  = dec_onehot(bus.wr_en, bus.wr_reg);

  // Register storage: single write port, every register writable incl. R0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     regs <= '0;
    else if (wr.en) regs[wr.addr] <= wr.data;
  end

  // Scoreboard next state: issue increments, writeback decrements, both cancel;
  // saturation and underflow hold the count and flag an error.
  always_comb begin
    cnt_nxt = cnt;
    err_set = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (iss_hit[i] && !wr_hit[i]) begin
        if (cnt[i] == SB_CNT_MAX) err_set    = 1'b1;
        else                      cnt_nxt[i] = cnt[i] + 1'b1;
      end else if (wr_hit[i] && !iss_hit[i]) begin
        if (cnt[i] == '0) err_set    = 1'b1;
        else              cnt_nxt[i] = cnt[i] - 1'b1;
      end
    end
  end

  // Scoreboard counters and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      sb_err <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      sb_err <= sb_err | err_set;
    end
  end

  assign rd_addr = {bus.rd2_reg, bus.rd1_reg};

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    rf_read_port u_rd (
      .regs (regs),
      .cnt  (cnt),
      .wr   (wr),
      .addr (rd_addr[p]),
      .rsp  (rd_rsp[p])
    );
  end

  assign bus.rd1_data  = rd_rsp[0].data;
  assign bus.rd1_busy  = rd_rsp[0].busy;
  assign bus.rd2_data  = rd_rsp[1].data;
  assign bus.rd2_busy  = rd_rsp[1].busy;
  assign bus.regs_flat = regs;
  assign bus.sb_err    = sb_err;

endmodule

// File: tb/tb_rf_core_8x16.sv
// Scoreboard bench for rf_core_8x16: stimulus queues expected values tagged
// with the cycle they apply to; a negedge monitor pops and compares them.
module tb_rf_core_8x16;
  import rf_core_8x16_pkg::*;

  typedef enum int {F_RD1D, F_RD2D, F_RD1B, F_RD2B, F_ERR, F_FLAT} fld_t;
  typedef struct {
    int           cyc;
    fld_t         fld;
    logic [127:0] exp;
    string        nm;
  } exp_t;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];

  rf_core_8x16_if bus();

  rf_core_8x16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] probe(input fld_t f);
    case (f)
      F_RD1D:  probe = {112'b0, bus.rd1_data};
      F_RD2D:  probe = {112'b0, bus.rd2_data};
      F_RD1B:  probe = {127'b0, bus.rd1_busy};
      F_RD2B:  probe = {127'b0, bus.rd2_busy};
      F_ERR:   probe = {127'b0, bus.sb_err};
      default: probe = bus.regs_flat;
    endcase
  endfunction

  task automatic exp_chk(input int dc, input fld_t f, input logic [127:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + dc;
    e.fld = f;
    e.exp = v;
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation that is due in the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t         e;
      logic [127:0] act;
      e   = q.pop_front();
      act = probe(e.fld);
      n_chk = n_chk + 1;
      if (e.cyc != cyc) begin
        n_err = n_err + 1;
        $display("FAIL %s: check missed its cycle (due %0d, now %0d)", e.nm, e.cyc, cyc);
      end else if (act !== e.exp) begin
        n_err = n_err + 1;
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", e.nm, act, e.exp, cyc);
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.issue_en  = 1'b0;
    bus.issue_reg = '0;
    bus.wr_en     = 1'b0;
    bus.wr_reg    = '0;
    bus.wr_data   = '0;
    bus.rd1_reg   = '0;
    bus.rd2_reg   = '0;

    // Reset then read
    step(); step();
    rst_n = 1'b1; bus.rd1_reg = 3'd3; bus.rd2_reg = 3'd7;
    exp_chk(0, F_RD1D, 0, "rst_rd1_data");
    exp_chk(0, F_RD2D, 0, "rst_rd2_data");
    exp_chk(0, F_RD1B, 0, "rst_rd1_busy");
    exp_chk(0, F_RD2B, 0, "rst_rd2_busy");
    exp_chk(0, F_ERR,  0, "rst_sb_err");
    exp_chk(0, F_FLAT, 0, "rst_flat");

    // Write/read latency on R5 (issued first so no underflow)
    step(); bus.issue_en = 1'b1; bus.issue_reg = 3'd5;
    step(); bus.issue_en = 1'b0;
    bus.wr_en = 1'b1; bus.wr_reg = 3'd5; bus.wr_data = 16'hBEEF;
    bus.rd1_reg = 3'd5; bus.rd2_reg = 3'd5;
    exp_chk(0, F_RD1D, BYP ? 16'hBEEF : 16'h0, "wr_cycle_rd1");
    exp_chk(0, F_RD2D, BYP ? 16'hBEEF : 16'h0, "wr_cycle_rd2");
    exp_chk(0, F_RD1B, BYP ? 1'b0 : 1'b1,      "wr_cycle_busy");
    step(); bus.wr_en = 1'b0;
    exp_chk(0, F_RD1D, 16'hBEEF, "wr_next_rd1");
    exp_chk(0, F_RD2D, 16'hBEEF, "wr_next_rd2");
    exp_chk(0, F_RD1B, 0,        "wr_next_busy");
    exp_chk(0, F_FLAT, 128'hBEEF << 80, "wr_flat_r5");
    exp_chk(0, F_ERR,  0,        "wr_no_err");

    // Scoreboard: two issues to R2, then two writes
    step(); bus.issue_en = 1'b1; bus.issue_reg = 3'd2; bus.rd1_reg = 3'd2;
    exp_chk(0, F_RD1B, 0, "sb_pre_issue");
    step();
    exp_chk(0, F_RD1B, 1, "sb_after_iss1");
    step(); bus.issue_en = 1'b0;
    bus.wr_en = 1'b1; bus.wr_reg = 3'd2; bus.wr_data = 16'h0222;
    exp_chk(0, F_RD1B, 1, "sb_cnt2_busy");
    step(); bus.wr_data = 16'h2222;
    exp_chk(0, F_RD1B, BYP ? 1'b0 : 1'b1, "sb_cnt1_busy");
    exp_chk(0, F_RD1D, BYP ? 16'h2222 : 16'h0222, "sb_cnt1_data");
    step(); bus.wr_en = 1'b0;
    exp_chk(0, F_RD1B, 0,        "sb_cleared");
    exp_chk(0, F_RD1D, 16'h2222, "sb_data_final");

    // Simultaneous issue and write to R4 with cnt=1
    step(); bus.issue_en = 1'b1; bus.issue_reg = 3'd4; bus.rd2_reg = 3'd4;
    step(); bus.wr_en = 1'b1; bus.wr_reg = 3'd4; bus.wr_data = 16'h4444;
    exp_chk(0, F_RD2B, BYP ? 1'b0 : 1'b1, "sim_cycle_busy");
    step(); bus.issue_en = 1'b0; bus.wr_en = 1'b0;
    exp_chk(0, F_RD2B, 1,        "sim_cnt_held");
    exp_chk(0, F_RD2D, 16'h4444, "sim_data");
    exp_chk(0, F_ERR,  0,        "sim_no_err");
    exp_chk(0, F_FLAT, (128'hBEEF << 80) | (128'h4444 << 64) | (128'h2222 << 32), "sim_flat");

    // Saturation: four issues to R1
    step(); bus.issue_en = 1'b1; bus.issue_reg = 3'd1; bus.rd1_reg = 3'd1;
    step(); step(); step();
    exp_chk(0, F_ERR,  0, "sat_pre_err");
    exp_chk(0, F_RD1B, 1, "sat_pre_busy");
    step(); bus.issue_en = 1'b0;
    bus.wr_en = 1'b1; bus.wr_reg = 3'd1; bus.wr_data = 16'h1111;
    exp_chk(0, F_ERR,  1, "sat_err");
    exp_chk(0, F_RD1B, 1, "sat_busy");
    step(); step();
    step(); bus.wr_en = 1'b0;
    exp_chk(0, F_RD1B, 0, "sat_drain_3");

    // Reset asserted between edges clears everything at once
    step(); rst_n = 1'b0;
    exp_chk(0, F_RD1D, 0, "rst1_rd1_data");
    exp_chk(0, F_RD2B, 0, "rst1_rd2_busy");
    exp_chk(0, F_ERR,  0, "rst1_sb_err");
    exp_chk(0, F_FLAT, 0, "rst1_flat");

    // Underflow: write R6 with cnt=0
    step(); rst_n = 1'b1;
    bus.wr_en = 1'b1; bus.wr_reg = 3'd6; bus.wr_data = 16'h6666; bus.rd2_reg = 3'd6;
    exp_chk(0, F_ERR, 0, "unf_pre_err");
    step(); bus.wr_en = 1'b0;
    exp_chk(0, F_RD2D, 16'h6666, "unf_data");
    exp_chk(0, F_ERR,  1,        "unf_err");
    exp_chk(0, F_RD2B, 0,        "unf_cnt_zero");

    // Async reset mid-op: R3 busy holding 16'h1234
    step(); bus.issue_en = 1'b1; bus.issue_reg = 3'd3;
    step();
    step(); bus.issue_en = 1'b0;
    bus.wr_en = 1'b1; bus.wr_reg = 3'd3; bus.wr_data = 16'h1234;
    step(); bus.wr_en = 1'b0; bus.rd1_reg = 3'd3;
    exp_chk(0, F_RD1B, 1,        "ar_busy");
    exp_chk(0, F_RD1D, 16'h1234, "ar_data");
    step(); #2 rst_n = 1'b0;
    exp_chk(0, F_RD1D, 0, "ar_rd1_data");
    exp_chk(0, F_RD1B, 0, "ar_rd1_busy");
    exp_chk(0, F_ERR,  0, "ar_sb_err");
    exp_chk(0, F_FLAT, 0, "ar_flat");
    step(); rst_n = 1'b1;

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      n_err = n_err + q.size();
      $display("FAIL drain: %0d expectations never checked", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rf_core_8x16.md
Name: rf_core_8x16

Overview:
- Architectural register file for the 16-bit WISC datapath: eight 16-bit registers, one write port, two read ports.
- Sits directly upstream of the 8:1 16-bit read-select muxes. It holds the register state those muxes select from, and it drives them internally for the two read ports.
- Also keeps a per-register pending-write scoreboard. Decode uses it to detect RAW hazards and stall.

Parameters:
- DATA_W, 16, register width in bits
- NREGS, 8, number of registers (fixed to 8; the address is 3 bits)
- CNT_W, 2, width of the per-register in-flight write counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- issue_en  input  1  an instruction writing issue_reg left decode this cycle
- issue_reg  input  3  destination register of the issuing instruction
- wr_en  input  1  writeback strobe
- wr_reg  input  3  writeback destination
- wr_data  input  16  writeback value
- rd1_reg  input  3  read port 1 address
- rd2_reg  input  3  read port 2 address
- rd1_data  output  16  read port 1 data
- rd2_data  output  16  read port 2 data
- rd1_busy  output  1  rd1_reg has an outstanding write
- rd2_busy  output  1  rd2_reg has an outstanding write
- regs_flat  output  128  all registers; R7 at [127:112], R0 at [15:0]
- sb_err  output  1  sticky scoreboard error flag

Behaviour:
- Reset: asserting rst_n low asynchronously clears all registers to 16'h0000, all counters to 0 and sb_err to 0.
  - Outputs after reset: rd*_data = 0, rd*_busy = 0, regs_flat = 0.
  - Reset asserted mid-operation discards all pending state immediately, with no clock needed.
- Write: on a rising edge with wr_en=1, R[wr_reg] <= wr_data.
  - All 8 registers are writable; R0 is not hardwired to zero.
- Read: combinational select from current register contents.
  - A write becomes visible on rd*_data and regs_flat the cycle after the edge that performs it.
  - Both ports may address the same register.
- Scoreboard: one CNT_W-bit counter per register, updated per rising edge.
  - Issue only (issue_en=1, no matching write): cnt[issue_reg]++.
  - Write only (wr_en=1, no matching issue): cnt[wr_reg]--.
  - Issue and write to the same register in one cycle: counter unchanged.
  - Issue and write to different registers: each counter updates independently.
  - Saturation: an issue to a register at cnt=3 holds the counter at 3 and sets sb_err.
  - Underflow: a write to a register at cnt=0 holds the counter at 0, sets sb_err, and the data write still occurs.
  - sb_err stays set until reset.
- Busy: rdN_busy = (cnt[rdN_reg] != 0). It is combinational and reflects registered counter state only, not this cycle's issue_en or wr_en.
- No internal FSM beyond the counters. Latency: write-to-read 1 cycle; issue-to-busy 1 cycle; write-to-not-busy 1 cycle.

Optional Feature:
- Macro: RF_BYPASS_EN.
- When defined:
  - If wr_en=1 and wr_reg == rdN_reg, rdN_data = wr_data in the same cycle (write-through bypass).
  - rdN_busy is forced to 0 when that write is the register's last outstanding one (cnt == 1).
  - regs_flat is never bypassed.
- When undefined: reads return registered contents only, exactly as above.

Decomposition:
- Shared package contents:
  - DATA_W, NREGS and ADDR_W = 3.
  - Typedef reg_addr_t (3 bits), reg_data_t (16 bits) and sb_cnt_t (CNT_W bits).
  - Constant SB_CNT_MAX = 3.
- One natural sub-module: rf_read_port, an 8:1 16-bit select plus busy lookup, instantiated once per read port.
- Storage and counters stay in the top level.

Test Plan:
- Reset then read: rst_n low for 2 cycles, release; rd1_reg=3, rd2_reg=7 -> rd1_data=0, rd2_data=0, busy both 0, sb_err=0, regs_flat=0.
- Write/read latency: wr_en, wr_reg=5, wr_data=16'hBEEF; rd1_reg=5 -> rd1_data=0 in the write cycle, 16'hBEEF the next cycle (16'hBEEF the same cycle with RF_BYPASS_EN); regs_flat[95:80]=16'hBEEF.
- Scoreboard: issue R2 twice on consecutive cycles -> rd1_busy=1 (rd1_reg=2); write R2 once -> still busy; write R2 again -> busy=0 the following cycle.
- Simultaneous events: R4 cnt=1; issue_en and wr_en both to R4 in one cycle -> cnt stays 1, busy stays 1, R4 takes wr_data.
- Error cases:
  - Four issues to R1 -> cnt holds 3, sb_err=1.
  - After reset, write R6 with cnt=0 -> R6 updated, sb_err=1.
- Async reset mid-op: R3 busy, R3=16'h1234; drop rst_n between clock edges -> all outputs 0 immediately, before the next edge.
